tlights_monitor: RTL
====================

TLIGHTS_MONITOR -- requirements
Module: tlights_monitor

Interface
REQ-001 Parameter STUCK_LIMIT, default 16: maximum consecutive sampled cycles one rag value may persist; legal range 2..255.
REQ-002 clk  input  1  clock; all state changes occur on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rag  input  3  observed light code {red,amber,green}, sampled every clk.
REQ-005 clear  input  1  synchronous pulse; clears fault and round count and forces resynchronisation.
REQ-006 in_sync  output  1  high while the monitor is tracking a verified sequence.
REQ-007 fault  output  1  sticky error flag.
REQ-008 fault_code  output  2  0 none, 1 illegal code, 2 bad transition, 3 stuck.
REQ-009 phase  output  2  decoded current light: 0 red, 1 red-amber, 2 green, 3 amber.
REQ-010 rounds  output  8  completed full cycles since the last reset or clear, saturating.

Function
REQ-011 Legal codes are 3'b100 red, 3'b110 red-amber, 3'b001 green and 3'b010 amber; every other code is illegal.
REQ-012 Legal successor order is 100->110->001->010->100; holding the current value is also legal, within the limit set by REQ-018.
REQ-013 All outputs are registered and reflect the rag value sampled on the previous edge (latency 1 cycle).
REQ-014 The FSM has three states: UNSYNC, TRACK and FAULT.
REQ-015 In UNSYNC:
- rag==100 -> TRACK, prev<=100, hold<=1.
- any other legal code -> remain in UNSYNC.
- illegal code -> FAULT with code 1.
REQ-016 In TRACK, when rag==prev: hold<=hold+1.
REQ-017 In TRACK, when rag==successor(prev): prev<=rag and hold<=1; if the step was 010->100, rounds increments, saturating at 255.
REQ-018 In TRACK:
- illegal rag -> FAULT with code 1.
- legal rag that is neither prev nor successor(prev) -> FAULT with code 2.
- rag==prev while hold==STUCK_LIMIT -> FAULT with code 3 (the value persisted for STUCK_LIMIT+1 samples).
REQ-019 Fault priority when several conditions apply in one cycle: code 1 > code 2 > code 3.
REQ-020 FAULT is sticky: rag is ignored, and fault, fault_code and rounds hold until clear or reset.
REQ-021 clear has priority over every other event in every state. On the next edge: state UNSYNC, fault 0, fault_code 0, rounds 0, hold 0.
REQ-022 in_sync is 1 exactly when state is TRACK; fault is 1 exactly when state is FAULT.
REQ-023 phase updates to the decode of every legal sampled rag in any state; on an illegal rag, phase holds its previous value.
REQ-024 hold is ceil(log2(STUCK_LIMIT+1)) bits wide and never wraps; REQ-018 traps it before overflow.

Reset
REQ-025 Asynchronous reset values:
- state UNSYNC.
- in_sync 0, fault 0, fault_code 0, phase 0, rounds 0.
- prev 3'b100, hold 0.
REQ-026 Reset asserted mid-operation immediately forces the REQ-025 values; after release, the monitor needs a fresh 100 to resynchronise.

Structure
REQ-027 Package tlights_pkg holds:
- the four rag code constants;
- the phase enum, the fault_code enum and the monitor state enum.
REQ-028 One combinational sub-module, tlights_decode, maps rag to {legal, phase, successor code}; tlights_monitor instantiates it once.

Verification
REQ-029 Basic tracking: reset, then drive 100,110,001,010 repeated for 3 rounds, then 100. Required: in_sync=1 one cycle after the first 100; rounds=3 one cycle after the final 100; fault=0 throughout.
REQ-030 Bad transition: drive 100,110,010. Required, one cycle after 010: fault=1, fault_code=2, in_sync=0; values hold while rag keeps toggling.
REQ-031 Illegal code: in TRACK, drive rag=111. Required: fault_code=1, and phase holds its prior value.
REQ-032 Stuck detection, STUCK_LIMIT=4:
- hold 110 for 4 samples, then 001 -> no fault.
- hold 110 for 5 samples -> fault_code=3 one cycle after the 5th sample.
REQ-033 Clear and resync:
- pulse clear in FAULT -> next cycle fault=0, fault_code=0, rounds=0, in_sync=0.
- a subsequent 100 -> in_sync=1.
REQ-034 Saturation and reset:
- run 260 legal rounds -> rounds=255.
- assert rst_n low asynchronously mid-TRACK -> all outputs reach REQ-025 values before the next edge.

Source files
------------

// File: rtl/tlights_pkg.sv
// tlights_pkg: shared light codes and state/phase/fault enums for the traffic-light monitor.
package tlights_pkg;
    localparam logic [2:0] RAG_RED       = 3'b100;
    localparam logic [2:0] RAG_RED_AMBER = 3'b110;
    localparam logic [2:0] RAG_GREEN     = 3'b001;
    localparam logic [2:0] RAG_AMBER     = 3'b010;

    typedef enum logic [1:0] {PH_RED, PH_RED_AMBER, PH_GREEN, PH_AMBER} phase_t;
    typedef enum logic [1:0] {FC_NONE, FC_ILLEGAL, FC_BAD_TRANS, FC_STUCK} fault_code_t;
    typedef enum logic [1:0] {ST_UNSYNC, ST_TRACK, ST_FAULT} state_t;
endpackage

// File: rtl/tlights_decode.sv
// tlights_decode: combinational decode of a rag code into legality, phase and successor code.
//   rag   - observed {red,amber,green}
//   legal - rag is one of the four legal codes
//   phase - decoded light (PH_RED for illegal codes)
//   succ  - next legal code in the cycle (RAG_RED for illegal codes)
module tlights_decode
    import tlights_pkg::*;
(
    input  logic [2:0] rag,
    output logic       legal,
    output phase_t     phase,
    output logic [2:0] succ
);
    always_comb begin
        legal = 1'b1;
        phase = PH_RED;
        succ  = RAG_RED;
        case (rag)
            RAG_RED:       begin phase = PH_RED;       succ = RAG_RED_AMBER; end
            RAG_RED_AMBER: begin phase = PH_RED_AMBER; succ = RAG_GREEN;     end
            RAG_GREEN:     begin phase = PH_GREEN;     succ = RAG_AMBER;     end
            RAG_AMBER:     begin phase = PH_AMBER;     succ = RAG_RED;       end
            default:       legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/tlights_monitor.sv
// tlights_monitor: checks a traffic-light code stream for legal codes, order and stuck lights.
//   clk, rst_n  - clock, asynchronous active-low reset
//   rag         - sampled light code {red,amber,green}
//   clear       - synchronous pulse: clears fault/rounds and forces resync
//   in_sync     - tracking a verified sequence
//   fault       - sticky error flag; fault_code gives the cause
//   phase       - decode of the last legal sample
//   rounds      - completed cycles (saturating at 255)
module tlights_monitor
    import tlights_pkg::*;
#(
    parameter int STUCK_LIMIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] rag,
    input  logic       clear,
    output logic       in_sync,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [1:0] phase,
    output logic [7:0] rounds
);
    localparam int HW = $clog2(STUCK_LIMIT + 1);

    state_t     state;
    logic [2:0] prev;
    logic [2:0] expect_next;
    logic [HW-1:0] hold;
    logic       legal;
    phase_t     dec_phase;
    logic [2:0] dec_succ;

    tlights_decode u_decode (
        .rag   (rag),
        .legal (legal),
        .phase (dec_phase),
        .succ  (dec_succ)
    );

    // The successor of prev is captured whenever prev is loaded, so a single
    // decoder on rag serves both the phase output and the order check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_UNSYNC;
            in_sync     <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
            phase       <= PH_RED;
            rounds      <= 8'd0;
            prev        <= RAG_RED;
            expect_next <= RAG_RED_AMBER;
            hold        <= '0;
        end else begin
            if (legal) phase <= dec_phase;
            if (clear) begin
                state       <= ST_UNSYNC;
                in_sync     <= 1'b0;
                fault       <= 1'b0;
                fault_code  <= FC_NONE;
                rounds      <= 8'd0;
                prev        <= RAG_RED;
                expect_next <= RAG_RED_AMBER;
                hold        <= '0;
            end else begin
                case (state)
                    ST_UNSYNC: begin
                        if (!legal) begin
                            state      <= ST_FAULT;
                            fault      <= 1'b1;
                            fault_code <= FC_ILLEGAL;
                        end else if (rag == RAG_RED) begin
                            state       <= ST_TRACK;
                            in_sync     <= 1'b1;
                            prev        <= rag;
                            expect_next <= dec_succ;
                            hold        <= HW'(1);
                        end
                    end
                    ST_TRACK: begin
                        if (!legal) begin
                            state      <= ST_FAULT;
                            in_sync    <= 1'b0;
                            fault      <= 1'b1;
                            fault_code <= FC_ILLEGAL;
                        end else if (rag == prev) begin
                            if (hold == HW'(STUCK_LIMIT)) begin
                                state      <= ST_FAULT;
                                in_sync    <= 1'b0;
                                fault      <= 1'b1;
                                fault_code <= FC_STUCK;
                            end else begin
                                hold <= hold + HW'(1);
                            end
                        end else if (rag == expect_next) begin
                            prev        <= rag;
                            expect_next <= dec_succ;
                            hold        <= HW'(1);
                            if (prev == RAG_AMBER && rounds != 8'hFF) rounds <= rounds + 8'd1;
                        end else begin
                            state      <= ST_FAULT;
                            in_sync    <= 1'b0;
                            fault      <= 1'b1;
                            fault_code <= FC_BAD_TRANS;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
